// File: rtl/afb_pkg.sv
// afb_pkg: shared types and constants for the FFT bin selector.
// Holds the FIFO entry bundle and the run-control state encoding.
package afb_pkg;

  localparam int AFB_N     = 1024;
  localparam int AFB_BIN_W = $clog2(AFB_N);
  localparam int AFB_WIDTH = 32;

  typedef struct packed {
    logic signed [AFB_WIDTH-1:0] i;
    logic signed [AFB_WIDTH-1:0] q;
    logic [AFB_BIN_W-1:0]        bin;
    logic                        last;
  } afb_sel_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    RUN
  } afb_state_t;

endpackage

// File: rtl/afb_bin_select_if.sv
// afb_bin_select_if: FFT input stream plus selected-bin output stream.
// slave = selector side (takes in_*, drives out_*); master = env side.
interface afb_bin_select_if #(
  parameter int WIDTH = 32,
  parameter int N     = 1024
);
  localparam int BW = $clog2(N);

  logic signed [WIDTH-1:0] in_inph;
  logic signed [WIDTH-1:0] in_quad;
  logic                    in_valid;

  logic signed [WIDTH-1:0] out_inph;
  logic signed [WIDTH-1:0] out_quad;
  logic [BW-1:0]           out_bin;
  logic                    out_last;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_inph,
    input  in_quad,
    input  in_valid,
    input  out_ready,
    output out_inph,
    output out_quad,
    output out_bin,
    output out_last,
    output out_valid
  );

  modport master (
    output in_inph,
    output in_quad,
    output in_valid,
    output out_ready,
    input  out_inph,
    input  out_quad,
    input  out_bin,
    input  out_last,
    input  out_valid
  );

endinterface

// File: rtl/afb_sel_fifo.sv
// afb_sel_fifo: first-word fall-through FIFO of selected bin entries.
// Ports: clk/rst_n, i_push/i_data, i_pop, o_data head, o_full/o_empty, o_drop.
import afb_pkg::*;

module afb_sel_fifo #(
  parameter int DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_push,
  input  afb_sel_entry_t i_data,
  input  logic           i_pop,
  output afb_sel_entry_t o_data,
  output logic           o_full,
  output logic           o_empty,
  output logic           o_drop
);

  localparam int AW = $clog2(DEPTH);

  afb_sel_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic           w_pop;
  logic           w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign w_pop   = i_pop & ~o_empty;
  // a pop frees the slot this cycle, so a full FIFO still takes the push
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_data  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/afb_bin_select.sv
// afb_bin_select: keeps a contiguous (possibly wrapping) FFT bin window.
// Ports: clock/reset_n, enable, first_bin/num_bins cfg, bus stream, overflow.
import afb_pkg::*;

module afb_bin_select #(
  parameter int WIDTH      = AFB_WIDTH,
  parameter int N          = AFB_N,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [$clog2(N)-1:0] first_bin,
  input  logic [$clog2(N):0]   num_bins,
  afb_bin_select_if.slave      bus,
  output logic                 overflow
);

  localparam int BW = $clog2(N);
  localparam int NW = BW + 1;

  afb_state_t r_state;
  afb_state_t w_state_nxt;

  logic [BW-1:0] r_bin;
  logic [BW-1:0] r_cfg_first;
  logic [NW-1:0] r_cfg_num;
  logic          r_stop;
  logic          r_s1_vld;
  logic          r_ovf;
  afb_sel_entry_t r_s1;

  logic [BW-1:0] w_first;
  logic [NW-1:0] w_num;
  logic [BW-1:0] w_diff;
  logic [NW-1:0] w_off;
  logic          w_keep;
  logic          w_last;
  logic          w_at_end;
  logic          w_sample;
  logic          w_latch;
  logic          w_full;
  logic          w_empty;
  logic          w_drop;
  afb_sel_entry_t w_head;

  logic signed [WIDTH-1:0] w_in_i;
  logic signed [WIDTH-1:0] w_in_q;

  assign w_in_i = bus.in_inph;
  assign w_in_q = bus.in_quad;

  // bin 0 arrives while still in SYNC, so compare against live cfg there
  assign w_first  = (r_state == SYNC) ? first_bin : r_cfg_first;
  assign w_num    = (r_state == SYNC) ? num_bins  : r_cfg_num;
  assign w_diff   = r_bin - w_first;
  assign w_off    = {1'b0, w_diff};
  assign w_keep   = (w_off < w_num);
  assign w_last   = (w_off == (w_num - NW'(1)));
  assign w_at_end = (r_bin == BW'(N - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_latch     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = SYNC;
      end
      SYNC: begin
        w_latch = 1'b1;
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (bus.in_valid) begin
          w_sample    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        w_sample = bus.in_valid;
        // cfg only moves at a frame boundary
        if (bus.in_valid && w_at_end) begin
          w_latch = 1'b1;
          if (r_stop || !enable) w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bin       <= '0;
      r_cfg_first <= '0;
      r_cfg_num   <= '0;
      r_stop      <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_s1        <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) r_bin <= '0;
      else if (w_sample)   r_bin <= r_bin + BW'(1);
      if (w_latch) begin
        r_cfg_first <= first_bin;
        r_cfg_num   <= num_bins;
      end
      // a dropped enable lets the current frame run out first
      r_stop   <= (w_state_nxt == RUN) & (r_stop | ~enable);
      r_s1_vld <= w_sample & w_keep;
      if (w_sample) begin
        r_s1 <= '{i: w_in_i, q: w_in_q,
                  bin: r_bin, last: w_last};
      end
      if (r_state == IDLE && enable) r_ovf <= 1'b0;
      else if (w_drop)               r_ovf <= 1'b1;
    end
  end

  afb_sel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset_n),
    .i_push  (r_s1_vld),
    .i_data  (r_s1),
    .i_pop   (bus.out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  // zero the data lanes when empty so idle outputs match reset values
  assign bus.out_valid = ~w_empty;
  assign bus.out_inph  = w_empty ? '0 : w_head.i;
  assign bus.out_quad  = w_empty ? '0 : w_head.q;
  assign bus.out_bin   = w_empty ? '0 : w_head.bin;
  assign bus.out_last  = ~w_empty & w_head.last;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_afb_bin_select.sv
// tb_afb_bin_select: directed checks of window, wrap, stall, cfg, enable, reset.
// Outputs are captured on the falling edge and compared to hand-derived values.
module tb_afb_bin_select;

  localparam int W  = 32;
  localparam int N  = 1024;
  localparam int BW = 10;

  typedef struct {
    int bin;
    int i;
    int q;
    int last;
    int cyc;
  } rec_t;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic [BW-1:0] first_bin = '0;
  logic [BW:0]   num_bins = '0;
  logic          overflow;

  afb_bin_select_if #(.WIDTH(W), .N(N)) bus ();

  afb_bin_select #(
    .WIDTH      (W),
    .N          (N),
    .FIFO_DEPTH (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .first_bin (first_bin),
    .num_bins  (num_bins),
    .bus       (bus.slave),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  int   in_cyc [N];
  int   tb_bin = 0;
  int   n_checks = 0;
  int   n_err = 0;
  rec_t got [$];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got.push_back('{bin: int'(bus.out_bin),
                      i: int'($signed(bus.out_inph)),
                      q: int'($signed(bus.out_quad)),
                      last: int'(bus.out_last),
                      cyc: cyc});
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b1;
      bus.in_inph  = tb_bin;
      bus.in_quad  = -tb_bin;
      in_cyc[tb_bin] = cyc;
      tick(1);
      tb_bin = (tb_bin + 1) % N;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    got.delete();
  endtask

  task automatic start();
    enable = 1'b1;
    tb_bin = 0;
    tick(1);
  endtask

  function automatic int gbin(input int k);
    return (k < got.size()) ? got[k].bin : -1;
  endfunction

  function automatic int glast(input int k);
    return (k < got.size()) ? got[k].last : -1;
  endfunction

  function automatic int gi(input int k);
    return (k < got.size()) ? got[k].i : -1;
  endfunction

  function automatic int gq(input int k);
    return (k < got.size()) ? got[k].q : -1;
  endfunction

  function automatic int glat(input int k);
    if (k >= got.size()) return -1;
    return got[k].cyc - in_cyc[got[k].bin];
  endfunction

  int n_last;
  int n_mid;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_inph   = '0;
    bus.in_quad   = '0;
    bus.out_ready = 1'b1;

    // reset state
    do_reset();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_last", int'(bus.out_last), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_inph", int'(bus.out_inph), 0);
    check("rst_bin", int'(bus.out_bin), 0);

    // simple window 4..6
    first_bin = 10'd4;
    num_bins  = 11'd3;
    start();
    send(N);
    tick(4);
    check("win_cnt", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      check("win_bin", gbin(k), 4 + k);
      check("win_i", gi(k), 4 + k);
      check("win_q", gq(k), -(4 + k));
      check("win_last", glast(k), (k == 2) ? 1 : 0);
      check("win_lat", glat(k), 2);
    end

    // wrapping window -401..0
    do_reset();
    first_bin = 10'd623;
    num_bins  = 11'd402;
    start();
    send(2 * N);
    tick(4);
    check("wrap_cnt", got.size(), 804);
    check("wrap_b0", gbin(0), 0);
    check("wrap_l0", glast(0), 1);
    check("wrap_b1", gbin(1), 623);
    check("wrap_l1", glast(1), 0);
    check("wrap_b401", gbin(401), 1023);
    check("wrap_b402", gbin(402), 0);
    check("wrap_l402", glast(402), 1);
    check("wrap_b403", gbin(403), 623);
    check("wrap_b803", gbin(803), 1023);
    n_last = 0;
    n_mid  = 0;
    foreach (got[k]) begin
      n_last += got[k].last;
      if (got[k].bin >= 1 && got[k].bin <= 622) n_mid++;
    end
    check("wrap_nlast", n_last, 2);
    check("wrap_nmid", n_mid, 0);

    // backpressure: 20 kept, 16 fit
    do_reset();
    first_bin     = 10'd0;
    num_bins      = 11'd20;
    bus.out_ready = 1'b0;
    start();
    send(25);
    check("bp_ovf", int'(overflow), 1);
    check("bp_valid", int'(bus.out_valid), 1);
    check("bp_held", got.size(), 0);
    bus.out_ready = 1'b1;
    enable        = 1'b0;
    send(N - 25);
    tick(4);
    check("bp_cnt", got.size(), 16);
    for (int k = 0; k < 16; k++) begin
      check("bp_bin", gbin(k), k);
    end
    check("bp_sticky", int'(overflow), 1);
    got.delete();
    start();
    check("bp_ovf_clr", int'(overflow), 0);
    send(N);
    tick(4);
    check("bp_f2_cnt", got.size(), 20);
    check("bp_f2_b19", gbin(19), 19);
    check("bp_f2_l19", glast(19), 1);
    check("bp_f2_ovf", int'(overflow), 0);

    // config change mid-frame
    do_reset();
    first_bin = 10'd10;
    num_bins  = 11'd8;
    start();
    send(500);
    num_bins = 11'd2;
    send(N - 500);
    tick(4);
    check("cfg_f1_cnt", got.size(), 8);
    check("cfg_f1_b0", gbin(0), 10);
    check("cfg_f1_b7", gbin(7), 17);
    check("cfg_f1_l7", glast(7), 1);
    got.delete();
    send(N);
    tick(4);
    check("cfg_f2_cnt", got.size(), 2);
    check("cfg_f2_b0", gbin(0), 10);
    check("cfg_f2_b1", gbin(1), 11);
    check("cfg_f2_l1", glast(1), 1);

    // enable drop at bin 300, window at frame end
    do_reset();
    first_bin     = 10'd1016;
    num_bins      = 11'd8;
    bus.out_ready = 1'b0;
    start();
    send(300);
    enable = 1'b0;
    send(N - 300);
    send(N);
    tick(4);
    check("en_held", got.size(), 0);
    check("en_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick(20);
    check("en_cnt", got.size(), 8);
    check("en_b0", gbin(0), 1016);
    check("en_b7", gbin(7), 1023);
    check("en_l7", glast(7), 1);
    check("en_ovf", int'(overflow), 0);
    check("en_empty", int'(bus.out_valid), 0);

    // async reset with a partly full FIFO
    do_reset();
    first_bin     = 10'd0;
    num_bins      = 11'd64;
    bus.out_ready = 1'b0;
    start();
    send(6);
    check("ar_pre_valid", int'(bus.out_valid), 1);
    check("ar_pre_bin", int'(bus.out_bin), 0);
    #3;
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    check("ar_valid", int'(bus.out_valid), 0);
    check("ar_last", int'(bus.out_last), 0);
    check("ar_bin", int'(bus.out_bin), 0);
    check("ar_inph", int'(bus.out_inph), 0);
    tick(2);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    first_bin     = 10'd3;
    num_bins      = 11'd2;
    got.delete();
    start();
    send(8);
    tick(4);
    check("ar_cnt", got.size(), 2);
    check("ar_b0", gbin(0), 3);
    check("ar_i0", gi(0), 3);
    check("ar_b1", gbin(1), 4);
    check("ar_l1", glast(1), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
